mult_shift_add_nb: RTL and testbench

Sequential unsigned shift-and-add multiplier. It drives the team's n-bit ripple-carry adder (`full_adder_nb`) one partial product per clock and consumes its `Sum`/`Cout` to build a 2n-bit product. The adder is instantiated internally with `Cin` tied to 0. This block is the iterative control/datapath stage that feeds the adder and collects its result.

---
 rtl/mult_shift_add_nb.sv | 141 ++++++++++++++
 tb/tb_mult_shift_add_nb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mult_shift_add_nb.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock
// through an internal n-bit ripple-carry adder, 2n-bit registered product.

module full_adder_nb #(
   parameter int n = 4
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         Cin,
   output logic [n-1:0] Sum,
   output logic         Cout
);

   logic [n:0] carry_s;

   assign carry_s[0] = Cin;

   for (genvar i = 0; i < n; i++) begin : g_bit
      assign Sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
   end

   assign Cout = carry_s[n];

endmodule

module mult_shift_add_nb #(
   parameter int n = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*n-1:0] product
);

   localparam int cw = $clog2(n) + 1;
   localparam logic [cw-1:0] last_cnt = cw'(n - 1);
   localparam logic [cw-1:0] one_cnt  = cw'(1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_r;
   logic [n-1:0]   m_r;
   logic [n-1:0]   acc_r;
   logic [n-1:0]   q_r;
   logic [cw-1:0]  cnt_r;
   logic           busy_r;
   logic           done_r;
   logic [2*n-1:0] product_r;

   logic [n-1:0]   addend_s;
   logic [n-1:0]   sum_s;
   logic           cout_s;

   // Partial product: multiplicand when the current multiplier bit is set.
   always_comb begin
      addend_s = {n{1'b0}};
      if (q_r[0]) begin
         addend_s = m_r;
      end else begin
         addend_s = {n{1'b0}};
      end
   end

   full_adder_nb #(.n(n)) u_adder (
      .a    (acc_r),
      .b    (addend_s),
      .Cin  (1'b0),
      .Sum  (sum_s),
      .Cout (cout_s)
   );

   // Control FSM and shift datapath. The adder carry lands in the top bit of
   // the accumulator after the right shift, so the separate carry bit is
   // always zero between iterations and needs no storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         m_r       <= {n{1'b0}};
         acc_r     <= {n{1'b0}};
         q_r       <= {n{1'b0}};
         cnt_r     <= {cw{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= {(2*n){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  m_r     <= a;
                  q_r     <= b;
                  acc_r   <= {n{1'b0}};
                  cnt_r   <= {cw{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= CALC;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            CALC: begin
               acc_r <= {cout_s, sum_s[n-1:1]};
               q_r   <= {sum_s[0], q_r[n-1:1]};
               cnt_r <= cnt_r + one_cnt;
               if (cnt_r == last_cnt) begin
                  product_r <= {cout_s, sum_s, q_r[n-1:1]};
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  state_r   <= DONE;
               end else begin
                  busy_r    <= 1'b1;
                  done_r    <= 1'b0;
                  state_r   <= CALC;
               end
            end
            DONE: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: tb/tb_mult_shift_add_nb.sv
// Self-checking bench for mult_shift_add_nb at n = 4 and n = 8, using a
// scoreboard queue of expected products per instance.

module tb_mult_shift_add_nb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start4 = 1'b0;
   logic [3:0]  a4 = 4'd0;
   logic [3:0]  b4 = 4'd0;
   logic        busy4;
   logic        done4;
   logic [7:0]  product4;
   logic        start8 = 1'b0;
   logic [7:0]  a8 = 8'd0;
   logic [7:0]  b8 = 8'd0;
   logic        busy8;
   logic        done8;
   logic [15:0] product8;

   int errors = 0;
   int checks = 0;
   logic [15:0] sb4[$];
   logic [15:0] sb8[$];
   logic [15:0] last4 = 16'd0;
   logic [15:0] last8 = 16'd0;

   mult_shift_add_nb #(.n(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(product4)
   );

   mult_shift_add_nb #(.n(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(product8)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive operands with start high; the next edge is the accepting edge E0.
   task automatic accept4(input logic [3:0] x, input logic [3:0] y);
      a4 = x;
      b4 = y;
      start4 = 1'b1;
      sb4.push_back(16'(x) * 16'(y));
      tick();
   endtask

   // Checks E0..En-1 busy, done at En with the scoreboard product, then hold.
   task automatic finish4(input string tag);
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_busy"}, {15'd0, busy4}, 16'd1);
         chk({tag, "_nodone"}, {15'd0, done4}, 16'd0);
         tick();
      end
      chk({tag, "_done"}, {15'd0, done4}, 16'd1);
      chk({tag, "_busy_off"}, {15'd0, busy4}, 16'd0);
      if (sb4.size() == 0) begin
         chk({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         last4 = sb4.pop_front();
         chk({tag, "_product"}, {8'd0, product4}, last4);
      end
      tick();
      chk({tag, "_done_pulse"}, {15'd0, done4}, 16'd0);
      chk({tag, "_hold"}, {8'd0, product4}, last4);
   endtask

   task automatic run4(input string tag, input logic [3:0] x, input logic [3:0] y);
      accept4(x, y);
      start4 = 1'b0;
      finish4(tag);
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] y);
      a8 = x;
      b8 = y;
      start8 = 1'b1;
      sb8.push_back(16'(x) * 16'(y));
      tick();
      start8 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("n8_busy", {15'd0, busy8}, 16'd1);
         chk("n8_nodone", {15'd0, done8}, 16'd0);
         tick();
      end
      chk("n8_done", {15'd0, done8}, 16'd1);
      if (sb8.size() == 0) begin
         chk("n8_sb_empty", 16'd1, 16'd0);
      end else begin
         last8 = sb8.pop_front();
         chk("n8_product", product8, last8);
      end
      tick();
      chk("n8_done_pulse", {15'd0, done8}, 16'd0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", {15'd0, busy4}, 16'd0);
      chk("rst_done", {15'd0, done4}, 16'd0);
      chk("rst_product", {8'd0, product4}, 16'd0);
      chk("rst_product8", product8, 16'd0);

      run4("m13x11", 4'd13, 4'd11);
      tick();
      chk("idle_hold", {8'd0, product4}, 16'd143);
      chk("idle_busy", {15'd0, busy4}, 16'd0);
      run4("m15x15", 4'd15, 4'd15);
      run4("m0x9", 4'd0, 4'd9);
      run4("m1x15", 4'd1, 4'd15);
      run4("m9x0", 4'd9, 4'd0);

      // start stays high with new operands through CALC and DONE
      accept4(4'd6, 4'd7);
      a4 = 4'd3;
      b4 = 4'd3;
      finish4("ign6x7");
      accept4(4'd3, 4'd3);
      start4 = 1'b0;
      finish4("ign3x3");

      // reset at E2 of a 12x12 multiply
      a4 = 4'd12;
      b4 = 4'd12;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_busy", {15'd0, busy4}, 16'd0);
      chk("mid_rst_done", {15'd0, done4}, 16'd0);
      chk("mid_rst_product", {8'd0, product4}, 16'd0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("mid_rst_no_done", {15'd0, done4}, 16'd0);
      end
      run4("m5x5", 4'd5, 4'd5);

      run8(8'd255, 8'd255);
      run8(8'd0, 8'd255);
      run8(8'd1, 8'd128);
      for (int k = 0; k < 200; k++) begin
         run8(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      end

      chk("sb4_drained", 16'(sb4.size()), 16'd0);
      chk("sb8_drained", 16'(sb8.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
